// File: rtl/mcp300x_pkg.sv
// mcp300x_pkg: shared states and sizes for the MCP300x SPI ADC slave model.
// MCP300X_SLAVE_LSBF_EN adds the TAIL state (LSB-first repeat after B0).
package mcp300x_pkg;
    localparam int CMD_BITS    = 4;
    localparam int DATA_BITS   = 10;
    localparam int SYNC_STAGES = 2;
`ifdef MCP300X_SLAVE_LSBF_EN
    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, NULL, DATA, TAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, NULL, DATA} state_t;
`endif
endpackage

// File: rtl/mcp300x_sync_edge.sv
// mcp300x_sync_edge: multi-flop synchronizer with rising/falling edge detect.
module mcp300x_sync_edge
    import mcp300x_pkg::*;
#(
    parameter logic INIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{INIT}};
            r_prev <= INIT;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q_o    = r_sync[SYNC_STAGES-1];
    assign rise_o = q_o & ~r_prev;
    assign fall_o = ~q_o & r_prev;
endmodule

// File: rtl/mcp300x_slave.sv
// mcp300x_slave: SPI slave emulating an MCP300x ADC (command decode, 10-bit readout).
// Define MCP300X_SLAVE_LSBF_EN to append the LSB-first B1..B9 tail after B0.
module mcp300x_slave
    import mcp300x_pkg::*;
#(
    parameter int FULL_RESET = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ad_ncs_i,
    input  logic       ad_clk_i,
    input  logic       ad_din_i,
    output logic       ad_dout_o,
    output logic       ad_dout_oe_o,
    output logic       req_o,
    output logic [2:0] chn_o,
    output logic       single_o,
    input  logic [9:0] data_i,
    output logic       eoc_o
);
    localparam logic [3:0] CMD_N  = 4'(CMD_BITS);
    localparam logic [3:0] DATA_N = 4'(DATA_BITS);
`ifdef MCP300X_SLAVE_LSBF_EN
    localparam logic [3:0] TAIL_N = 4'(DATA_BITS - 1);
`endif

    logic w_ncs, w_ncs_rise, w_ncs_fall;
    logic w_sclk, w_rise, w_fall;
    logic w_din, w_din_rise, w_din_fall;
    logic w_unused;

    state_t     r_state, w_next;
    logic [9:0] r_shift, w_shift_n;
    logic [3:0] r_cnt, w_cnt_n;
    logic       r_dout, w_dout_n, r_oe, w_oe_n, r_req, w_req_n, r_eoc, w_eoc_n;
    logic       r_single, w_single_n;
    logic [2:0] r_chn, w_chn_n;

    mcp300x_sync_edge #(.INIT(1'b1)) u_ncs (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ad_ncs_i),
        .q_o(w_ncs), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
    );
    mcp300x_sync_edge #(.INIT(1'b0)) u_clk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ad_clk_i),
        .q_o(w_sclk), .rise_o(w_rise), .fall_o(w_fall)
    );
    mcp300x_sync_edge #(.INIT(1'b0)) u_din (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ad_din_i),
        .q_o(w_din), .rise_o(w_din_rise), .fall_o(w_din_fall)
    );

    assign w_unused = &{1'b0, w_ncs_rise, w_ncs_fall, w_sclk, w_din_rise, w_din_fall};

    // Readout rotates rather than shifts so the word is intact again after B0 for the tail.
    always_comb begin
        w_next     = r_state;
        w_shift_n  = r_shift;
        w_cnt_n    = r_cnt;
        w_dout_n   = r_dout;
        w_oe_n     = r_oe;
        w_req_n    = 1'b0;
        w_eoc_n    = 1'b0;
        w_chn_n    = r_chn;
        w_single_n = r_single;
        if (w_ncs) begin
            w_next   = IDLE;
            w_dout_n = 1'b0;
            w_oe_n   = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_next = WAIT_START;
                WAIT_START: begin
                    if (w_rise && w_din) begin
                        w_next  = CMD;
                        w_cnt_n = '0;
                    end
                end
                CMD: begin
                    if (w_rise && r_cnt != CMD_N) begin
                        w_shift_n = {r_shift[8:0], w_din};
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_cnt == CMD_N - 4'd1) begin
                            w_req_n    = 1'b1;
                            w_single_n = r_shift[2];
                            w_chn_n    = {r_shift[1:0], w_din};
                        end
                    end else if (w_fall && r_cnt == CMD_N) begin
                        w_shift_n = data_i;
                        w_dout_n  = 1'b0;
                        w_oe_n    = 1'b1;
                        w_next    = NULL;
                    end
                end
                NULL: begin
                    if (w_fall) begin
                        w_dout_n  = r_shift[9];
                        w_shift_n = {r_shift[8:0], r_shift[9]};
                        w_cnt_n   = 4'd1;
                        w_next    = DATA;
                    end
                end
                DATA: begin
                    if (w_fall && r_cnt != DATA_N) begin
                        w_dout_n  = r_shift[9];
                        w_shift_n = {r_shift[8:0], r_shift[9]};
                        w_cnt_n   = r_cnt + 4'd1;
                        if (r_cnt == DATA_N - 4'd1) begin
                            w_eoc_n = 1'b1;
`ifdef MCP300X_SLAVE_LSBF_EN
                            w_next  = TAIL;
                            w_cnt_n = '0;
`endif
                        end
                    end else if (w_fall) begin
                        w_dout_n = 1'b0;
                    end
                end
`ifdef MCP300X_SLAVE_LSBF_EN
                TAIL: begin
                    if (w_fall && r_cnt != TAIL_N) begin
                        w_dout_n  = r_shift[1];
                        w_shift_n = {1'b0, r_shift[9:1]};
                        w_cnt_n   = r_cnt + 4'd1;
                    end else if (w_fall) begin
                        w_dout_n = 1'b0;
                    end
                end
`endif
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dout   <= 1'b0;
            r_oe     <= 1'b0;
            r_req    <= 1'b0;
            r_eoc    <= 1'b0;
            r_chn    <= '0;
            r_single <= 1'b0;
        end else begin
            r_dout   <= w_dout_n;
            r_oe     <= w_oe_n;
            r_req    <= w_req_n;
            r_eoc    <= w_eoc_n;
            r_chn    <= w_chn_n;
            r_single <= w_single_n;
        end
    end

    // The shift register and counter are always loaded before use, so their reset is optional.
    if (FULL_RESET != 0) begin : g_full_rst
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_shift_n;
                r_cnt   <= w_cnt_n;
            end
        end
    end else begin : g_lean_rst
        always_ff @(posedge clk_i) begin
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign ad_dout_o    = r_dout;
    assign ad_dout_oe_o = r_oe;
    assign req_o        = r_req;
    assign eoc_o        = r_eoc;
    assign chn_o        = r_chn;
    assign single_o     = r_single;
endmodule

// File: doc/mcp300x_slave.md
MCP300X_SLAVE -- requirements
Module: mcp300x_slave

Interface
REQ-001 SHALL provide parameter FULL_RESET, default 1, meaning: reset clears all registers, including datapath registers that do not need it.
REQ-002 SHALL provide these ports:
- clk_i, input, 1 bit: system clock.
- rst_i, input, 1 bit: system reset, asynchronous, active-high.
- ad_ncs_i, input, 1 bit: SPI /CS from the master.
- ad_clk_i, input, 1 bit: SPI clock (mode 0,0).
- ad_din_i, input, 1 bit: SPI MOSI.
- ad_dout_o, output, 1 bit: SPI MISO value.
- ad_dout_oe_o, output, 1 bit: MISO output enable; 0 means the pad is released.
- req_o, output, 1 bit: 1-cycle pulse; a command has been decoded.
- chn_o, output, 3 bits: requested channel (D2..D0).
- single_o, output, 1 bit: SGL/DIFF bit (1 = single-ended).
- data_i, input, 10 bits: conversion value to return to the master.
- eoc_o, output, 1 bit: 1-cycle pulse; B0 has been driven.

Function
REQ-003 SHALL pass ad_ncs_i, ad_clk_i and ad_din_i through 2-flop synchronizers, then detect ad_clk rising and falling edges; clk_i SHALL be at least 8x the SPI clock.
REQ-004 SHALL use the states IDLE, WAIT_START, CMD, NULL, DATA, TAIL.
- IDLE goes to WAIT_START when synchronized ncs = 0.
REQ-005 In WAIT_START, SHALL sample din on each SPI rising edge, ignore leading 0s, and go to CMD on the first 1 (start bit).
REQ-006 In CMD, SHALL shift 4 bits in on rising edges: SGL/DIFF, D2, D1, D0.
- After D0, SHALL update single_o/chn_o and pulse req_o on the following clk_i cycle.
REQ-007 On the first SPI falling edge after D0, SHALL:
- latch data_i into the shift register;
- drive ad_dout_o = 0 (null bit) and ad_dout_oe_o = 1;
- enter NULL.
REQ-008 SHALL drive B9..B0, MSB first, on the next 10 falling edges (DATA).
- The falling edge that drives B0 SHALL pulse eoc_o one cycle later.
- The state SHALL then enter TAIL.
REQ-009 TAIL behaviour is set by REQ-015/REQ-016.
- Once TAIL is exhausted, ad_dout_o SHALL hold 0 with oe = 1 until ncs rises.
REQ-010 Synchronized ncs = 1 in any state SHALL, within 1 clk_i cycle:
- force IDLE;
- set ad_dout_oe_o = 0 and ad_dout_o = 0;
- abort the transaction with no eoc_o (a req_o already issued stands).
REQ-011 SHALL use a 4-bit bit counter; it SHALL never wrap; further SPI edges in the terminal state SHALL be ignored.
REQ-012 SHALL ignore ad_din_i after the start bit except during CMD.
- Simultaneous ncs rise and SPI edge: ncs wins.

Reset
REQ-013 While rst_i = 1, SHALL hold:
- state = IDLE;
- ad_dout_o = 0, ad_dout_oe_o = 0;
- req_o = 0, eoc_o = 0;
- chn_o = 0, single_o = 0;
- synchronizers set to ncs = 1, clk = 0, din = 0.
REQ-014 With FULL_RESET = 0, the shift register and bit counter SHALL be left unreset.
- They SHALL be loaded before use.

Configuration
REQ-015 With MCP300X_SLAVE_LSBF_EN defined, after B0 the TAIL state SHALL drive B1..B9 on the next 9 falling edges, matching real MCP3008 LSB-first output.
REQ-016 Without MCP300X_SLAVE_LSBF_EN, after B0 the block SHALL drive 0, and the TAIL state and its logic SHALL not exist.

Structure
REQ-017 A shared package mcp300x_pkg SHALL hold:
- the state enum;
- constants CMD_BITS = 4, DATA_BITS = 10, SYNC_STAGES = 2.
REQ-018 One sub-module, mcp300x_sync_edge, SHALL hold the 2-flop synchronizer plus rise/fall detect, instantiated three times (ncs, clk, din; edge outputs unused where not needed).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Master sends 0,0,1,1,1,1,0 (leading zeros, start bit, single-ended, channel 6) with data_i = 0x2A5 -> req_o once, chn_o = 6, single_o = 1; MISO shows null 0, then 1010100101; eoc_o pulses once.
- Differential, channel 3 (start, 0, 0, 1, 1), data_i = 0x3FF -> single_o = 0, chn_o = 3; MISO shows 0 then ten 1s.
- LSBF_EN defined, data_i = 0x201, 20 clocks after D0 -> MISO shows 0, 1000000001, 000000001; LSBF_EN undefined -> 0, 1000000001, then 0s.
- ncs raised after 4 data bits -> oe = 0 within 3 clk_i, no eoc_o; the next transaction, channel 1, decodes correctly.
- rst_i asserted during DATA -> outputs drop to reset values immediately; after release, a full channel-0 transaction passes.
- data_i changed between req_o and the null falling edge -> the value present at the null edge is returned.
